// File: rtl/seq_ctl_pkg.sv
// Shared definitions for the accumulator sequencer: instruction field
// positions, opcodes, FSM state encoding and the ALU select bundle.
package seq_ctl_pkg;

  // Instruction fields: op = IR[15:12], arg = IR[11:0]
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int ARG_W  = 12;

  localparam logic [3:0] OP_NAD = 4'h0;
  localparam logic [3:0] OP_SHR = 4'h1;
  localparam logic [3:0] OP_SHL = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPFETCH, S_EXEC, S_STORE, S_HALT
  } state_e;

  // One-hot ALU operation select for the EXEC cycle
  typedef struct packed {
    logic nad;
    logic shr;
    logic shl;
  } alu_sel_t;

endpackage

// File: rtl/seq_ctl_decode.sv
// Combinational opcode decoder.
//   op        in   4  instruction opcode
//   nxt_state out     state to enter after DECODE
//   alu_sel   out     one-hot ALU operation for EXEC (all zero if none)
module seq_ctl_decode
  import seq_ctl_pkg::*;
(
  input  logic [3:0] op,
  output state_e     nxt_state,
  output alu_sel_t   alu_sel
);

  always_comb begin
    nxt_state = S_FETCH;
    alu_sel   = '0;
    case (op)
      OP_NAD: begin nxt_state = S_OPFETCH; alu_sel.nad = 1'b1; end
      OP_SHR: begin nxt_state = S_EXEC;    alu_sel.shr = 1'b1; end
      OP_SHL: begin nxt_state = S_EXEC;    alu_sel.shl = 1'b1; end
      OP_STA: nxt_state = S_STORE;
      OP_HLT: nxt_state = S_HALT;
      default: ; // LDI/JZ/JMP and 8-F return straight to FETCH
    endcase
  end

endmodule

// File: rtl/seq_ctl.sv
// Instruction sequencer for the 16-bit accumulator datapath. Master side of
// the ALU control interface; owns acc, pc, ir and operand registers.
//   clk, rst_n             clock, async active-low reset
//   mem_req/we/addr/wdata  registered memory request (stable until ack)
//   mem_rdata, mem_ack     memory response (ack is a 1-cycle pulse)
//   acc_data/mem_data/arg_data  ALU data inputs
//   result, is_zero        ALU outputs
//   ctl_nad/shr/shl/lda    one-hot ALU selects
//   halted                 high in HALT
module seq_ctl
  import seq_ctl_pkg::*;
#(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc_data,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] arg_data,
  input  logic [DATA_W-1:0] result,
  input  logic              is_zero,
  output logic              ctl_nad,
  output logic              ctl_shr,
  output logic              ctl_shl,
  output logic              ctl_lda,
  output logic              halted
);

  state_e              state, state_d, dec_state;
  alu_sel_t            dec_sel;
  logic [ADDR_W-1:0]   pc, pc_d, addr_d, arg_addr;
  logic [DATA_W-1:0]   acc, acc_d, ir, ir_d, opnd, opnd_d, wdata_d;
  logic                req_d, we_d, ack;

  seq_ctl_decode u_dec (
    .op        (ir[OP_HI:OP_LO]),
    .nxt_state (dec_state),
    .alu_sel   (dec_sel)
  );

  assign arg_addr = ir[ADDR_W-1:0];
  assign arg_data = {{(DATA_W-ARG_W){1'b0}}, ir[ARG_W-1:0]};
  assign acc_data = acc;
  assign mem_data = opnd;
  assign ack      = mem_req & mem_ack;  // stray acks are ignored

  // ir is held through EXEC, so the decoder select stays valid there
  assign ctl_nad = (state == S_EXEC) & dec_sel.nad;
  assign ctl_shr = (state == S_EXEC) & dec_sel.shr;
  assign ctl_shl = (state == S_EXEC) & dec_sel.shl;
  assign ctl_lda = (state == S_STORE);
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      acc       <= '0;
      ir        <= '0;
      opnd      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      acc       <= acc_d;
      ir        <= ir_d;
      opnd      <= opnd_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // Requests are launched on the transition into the state that owns them,
  // so a zero-wait ack can land in that state's first cycle. After reset or
  // STORE, FETCH spends one cycle raising its own request.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    acc_d   = acc;
    ir_d    = ir;
    opnd_d  = opnd;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state)
      S_FETCH: begin
        if (!mem_req) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc;
        end else if (ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc + ADDR_W'(1);
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = dec_state;
        case (ir[OP_HI:OP_LO])
          OP_LDI: acc_d = arg_data;
          OP_JZ:  if (is_zero) pc_d = arg_addr;
          OP_JMP: pc_d = arg_addr;
          default: ;
        endcase
        case (dec_state)
          S_FETCH:   begin req_d = 1'b1; we_d = 1'b0; addr_d = pc_d; end
          S_OPFETCH: begin req_d = 1'b1; we_d = 1'b0; addr_d = arg_addr; end
          // ctl_lda passes acc through the ALU, so result == acc in STORE;
          // latching acc lets wdata be registered before STORE begins.
          S_STORE:   begin req_d = 1'b1; we_d = 1'b1; addr_d = arg_addr;
                           wdata_d = acc; end
          default: ;
        endcase
      end
      S_OPFETCH: begin
        if (ack) begin
          opnd_d  = mem_rdata;
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d   = result;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = pc;
        state_d = S_FETCH;
      end
      S_STORE: begin
        if (ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: ; // S_HALT: absorbing
    endcase
  end

endmodule
